// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared width helpers and parameter legality checks for sync_fifo_param
package fifo_pkg;

   // Memory address width: the low pointer bits.
   function automatic int unsigned addr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Pointer/count width: one extra bit so count can reach DEPTH and pointers carry a wrap bit.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit params_ok(input int width, input int depth,
                                    input int af_thresh, input int ae_thresh,
                                    input int fwft);
      return (width >= 1) && (depth >= 2) && is_pow2(depth) &&
             (af_thresh >= 1) && (af_thresh <= depth) &&
             (ae_thresh >= 0) && (ae_thresh <= depth - 1) &&
             ((fwft == 0) || (fwft == 1));
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x WIDTH simple dual-port array, synchronous write, asynchronous read
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
module fifo_ram #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage is deliberately not reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with optional first-word-fall-through
// Ports: clk, rst_n (async active-low); wr_en/wr_data write side; rd_en/rd_data read side;
//        full/empty/almost_full/almost_empty/count status; overflow/underflow rejection pulses.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 1,
   parameter int FWFT      = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int ADDR_W = addr_w(DEPTH);
   localparam int CNT_W  = cnt_w(DEPTH);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

   if (!params_ok(WIDTH, DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : g_bad_params
      $error("sync_fifo_param: illegal parameter set");
   end

   logic [CNT_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] rd_data_q;
   logic [WIDTH-1:0] ram_rdata;
   logic             full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
   logic             ov_q, ov_d;        // FWFT output register holds a valid word
   logic             mem_empty;
   logic             rd_acc, wr_acc, refill, empty_d;

   fifo_ram #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q[ADDR_W-1:0]),
      .wdata (wr_data),
      .raddr (rd_ptr_q[ADDR_W-1:0]),
      .rdata (ram_rdata)
   );

   always_comb begin
      mem_empty = (wr_ptr_q == rd_ptr_q);
      if (FWFT != 0) begin
         // A pop only needs a valid output word; memory refills it whenever it has data
         // and the output register is free or being vacated at this edge.
         rd_acc = rd_en && ov_q;
         refill = !mem_empty && (!ov_q || rd_acc);
         ov_d   = refill || (ov_q && !rd_acc);
      end else begin
         rd_acc = rd_en && !empty_q;
         refill = rd_acc;
         ov_d   = 1'b0;
      end
      // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
      wr_acc  = wr_en && (!full_q || rd_acc);
      count_d = count_q + (wr_acc ? ONE : '0) - (rd_acc ? ONE : '0);
      empty_d = (FWFT != 0) ? !ov_d : (count_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
         ov_q      <= 1'b0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         af_q      <= 1'b0;
         ae_q      <= 1'b1;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_q <= wr_ptr_q + ONE;
         end
         if (refill) begin
            rd_ptr_q  <= rd_ptr_q + ONE;
            rd_data_q <= ram_rdata;
         end
         ov_q    <= ov_d;
         count_q <= count_d;
         full_q  <= (count_d == DEPTH_C);
         empty_q <= empty_d;
         af_q    <= (count_d >= AF_C);
         ae_q    <= (count_d <= AE_C);
         ovf_q   <= wr_en && !wr_acc;
         udf_q   <= rd_en && !rd_acc;
      end
   end

   assign rd_data      = rd_data_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed table-driven bench for sync_fifo_param
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   // DUT 0: standard read mode
   logic       wr_en0 = 1'b0, rd_en0 = 1'b0;
   logic [7:0] wr_data0 = '0, rd_data0;
   logic       full0, empty0, af0, ae0, ovf0, udf0;
   logic [3:0] count0;

   // DUT 1: first-word-fall-through mode
   logic       wr_en1 = 1'b0, rd_en1 = 1'b0;
   logic [7:0] wr_data1 = '0, rd_data1;
   logic       full1, empty1, af1, ae1, ovf1, udf1;
   logic [3:0] count1;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0),
      .rd_data(rd_data0), .full(full0), .empty(empty0), .almost_full(af0),
      .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(udf0)
   );

   sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
      .rd_data(rd_data1), .full(full1), .empty(empty1), .almost_full(af1),
      .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(udf1)
   );

   typedef struct {
      logic       wr;
      logic [7:0] d;
      logic       rd;
      logic [7:0] rdata;
      logic [3:0] cnt;
      logic       ovf;
      logic       udf;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic wr, input logic [7:0] d, input logic rd,
                               input logic [7:0] rdata, input logic [3:0] cnt,
                               input logic ovf, input logic udf);
      vec_t v;
      v.wr = wr; v.d = d; v.rd = rd; v.rdata = rdata; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
      vecs.push_back(v);
   endfunction

   // {rd_data, count, full, empty, almost_full, almost_empty, overflow, underflow}
   function automatic logic [31:0] pack(input logic [7:0] rdata, input logic [3:0] cnt,
                                        input logic f, input logic e, input logic af,
                                        input logic ae, input logic ov, input logic ud);
      return {14'd0, rdata, cnt, f, e, af, ae, ov, ud};
   endfunction

   function automatic logic [31:0] status0();
      return pack(rd_data0, count0, full0, empty0, af0, ae0, ovf0, udf0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp;
      string nm;

      // ---- vector table: standard mode ----
      for (int i = 1; i <= 8; i++) add(1, 8'(i), 0, 8'h00, 4'(i), 0, 0);
      add(1, 8'hFF, 0, 8'h00, 4'd8, 1, 0);                               // overflow at full
      for (int i = 1; i <= 8; i++) add(0, 8'h00, 1, 8'(i), 4'(8 - i), 0, 0);
      add(0, 8'h00, 1, 8'h08, 4'd0, 0, 1);                               // underflow, data holds
      add(0, 8'h00, 0, 8'h08, 4'd0, 0, 0);                               // pulse lasts one cycle
      for (int i = 0; i < 5; i++) add(1, 8'(8'h20 + i), 0, 8'h08, 4'(i + 1), 0, 0);
      for (int i = 0; i < 5; i++) add(0, 8'h00, 1, 8'(8'h20 + i), 4'(4 - i), 0, 0);
      for (int i = 0; i < 8; i++) add(1, 8'(8'h10 + i), 0, 8'h24, 4'(i + 1), 0, 0);  // wrap
      add(1, 8'hAA, 1, 8'h10, 4'd8, 0, 0);                               // simultaneous at full
      for (int i = 1; i <= 7; i++) add(0, 8'h00, 1, 8'(8'h10 + i), 4'(8 - i), 0, 0);
      add(0, 8'h00, 1, 8'hAA, 4'd0, 0, 0);
      add(1, 8'h55, 1, 8'hAA, 4'd1, 0, 1);                               // simultaneous at empty
      add(0, 8'h00, 1, 8'h55, 4'd0, 0, 0);

      // ---- reset state ----
      rst_n = 1'b0;
      step();
      step();
      chk("reset_dut0", status0(), pack(8'h00, 4'd0, 0, 1, 0, 1, 0, 0));
      chk("reset_dut1", {rd_data1, count1, full1, empty1, ae1},
          {8'h00, 4'd0, 1'b0, 1'b1, 1'b1});
      rst_n = 1'b1;
      step();

      // ---- table ----
      foreach (vecs[k]) begin
         wr_en0 = vecs[k].wr; wr_data0 = vecs[k].d; rd_en0 = vecs[k].rd;
         step();
         exp = pack(vecs[k].rdata, vecs[k].cnt, vecs[k].cnt == 4'd8, vecs[k].cnt == 4'd0,
                    vecs[k].cnt >= 4'd6, vecs[k].cnt <= 4'd1, vecs[k].ovf, vecs[k].udf);
         nm = $sformatf("vec%0d", k);
         chk(nm, status0(), exp);
      end
      wr_en0 = 0; rd_en0 = 0;

      // ---- FWFT: single word falls through with latency 1 ----
      wr_en1 = 1; wr_data1 = 8'h5A;
      step();
      wr_en1 = 0;
      chk("fwft_after_N", {count1, empty1}, {4'd1, 1'b1});
      step();
      chk("fwft_after_N1", {rd_data1, count1, empty1}, {8'h5A, 4'd1, 1'b0});
      rd_en1 = 1;
      step();
      rd_en1 = 0;
      chk("fwft_pop", {count1, empty1, udf1}, {4'd0, 1'b1, 1'b0});

      // ---- FWFT: back-to-back words, pop refills at the same edge ----
      wr_en1 = 1; wr_data1 = 8'h61;
      step();
      wr_data1 = 8'h62;
      step();
      wr_en1 = 0;
      chk("fwft_two_words", {rd_data1, count1, empty1}, {8'h61, 4'd2, 1'b0});
      rd_en1 = 1;
      step();
      chk("fwft_refill", {rd_data1, count1, empty1}, {8'h62, 4'd1, 1'b0});
      step();
      chk("fwft_drained", {count1, empty1, udf1}, {4'd0, 1'b1, 1'b0});
      step();
      rd_en1 = 0;
      chk("fwft_underflow", {count1, empty1, udf1}, {4'd0, 1'b1, 1'b1});

      // ---- asynchronous reset mid-burst ----
      wr_en0 = 1; wr_data0 = 8'h31; wr_en1 = 1; wr_data1 = 8'h41;
      step();
      step();
      step();
      chk("burst_count", {28'd0, count0}, 32'd3);
      #3;                      // well away from any rising edge
      rst_n = 1'b0;
      #1;
      chk("async_reset_dut0", status0(), pack(8'h00, 4'd0, 0, 1, 0, 1, 0, 0));
      chk("async_reset_dut1", {rd_data1, count1, empty1}, {8'h00, 4'd0, 1'b1});
      wr_en0 = 0; wr_en1 = 0;
      step();
      rst_n = 1'b1;
      step();
      chk("post_reset_idle", status0(), pack(8'h00, 4'd0, 0, 1, 0, 1, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO; the next-generation replacement for the fixed 8-deep buffer. It adds arbitrary power-of-two depth, occupancy count, programmable almost-full/almost-empty, overflow/underflow pulses and an optional first-word-fall-through (FWFT) read mode. It sits between any same-clock producer and consumer in the datapath.

## Interface
- WIDTH, 8: data word width, ≥1.
- DEPTH, 8: number of entries. Must be a power of two, ≥2.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH. Range 1..DEPTH.
- AE_THRESH, 1: almost_empty asserts when count ≤ AE_THRESH. Range 0..DEPTH-1.
- FWFT, 0: 0 = standard read (data follows rd_en); 1 = first-word-fall-through.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous and active-low. Assertion clears all state immediately. Deassertion is synchronised externally.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data, sampled with wr_en.
- rd_en  in  1  read/pop request.
- rd_data  out  WIDTH  read data, registered.
- full  out  1  no free entry.
- empty  out  1  no readable word.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  $clog2(DEPTH)+1  words held, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

## Operation
- Reset values:
  - rd_data=0, count=0, full=0, empty=1.
  - almost_full=0, almost_empty=1.
  - overflow=0, underflow=0.
  - Both pointers 0. Memory contents are not reset.
- Pointers are $clog2(DEPTH)+1 bits. The low bits address memory; the MSB is the wrap bit.
  - Equal pointers: empty. Low bits equal and MSBs differ: full.
  - Wrap from DEPTH-1 to 0 is natural binary rollover.
- Write accepted when wr_en && (!full || read accepted same cycle). Otherwise, if wr_en is high, overflow pulses and memory and pointer are unchanged.
- Read accepted when rd_en && !empty. Otherwise, if rd_en is high, underflow pulses and rd_data holds.
- Simultaneous accepted read and write: count unchanged.
  - When full: both are accepted.
  - When empty: only the write is accepted and underflow pulses.
- All flags and count are registered and derived from the next-state count, so they are exact on the cycle after the causing edge. There is no one-cycle-stale flag.
- FWFT=0: on an accepted read, rd_data is loaded with the head word at that edge.
- FWFT=1: a one-word output register holds the head.
  - empty = output register invalid. rd_data shows the head whenever empty=0.
  - rd_en pops the head; the register refills from memory at the same edge if memory is non-empty.
  - count includes the output register word.

## Timing
- Write at edge N: count and flags reflect it after edge N.
- FWFT=0: first write to an empty FIFO at edge N gives empty=0 after N. A read at N+1 presents data after N+1 (read latency 1).
- FWFT=1: first write to an empty FIFO at edge N gives empty=0 and valid rd_data after N+1 (fall-through latency 1).
- overflow/underflow are high for exactly the cycle after the rejected request's edge.
- Reset assertion mid-transfer forces reset values asynchronously. Words in flight are discarded.

## Structure
- Shared package fifo_pkg holds:
  - clog2-derived width constants: ADDR_W, CNT_W.
  - Parameter legality checks: DEPTH power of two, threshold ranges. Elaboration fails on illegal parameters.
- Sub-module fifo_ram: DEPTH×WIDTH simple dual-port array with a synchronous write port and an asynchronous-read address port. The top level owns pointers, flags, count and the FWFT stage.

## Test plan
All scenarios use WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1 unless noted.
- Reset: hold rst_n=0 → empty=1, almost_empty=1, full=0, count=0, rd_data=0. Assert rst_n mid-burst → same values without a clock edge.
- Fill/drain, FWFT=0: write 0x01..0x08 → almost_full rises after the 6th write, full after the 8th, count=8. A 9th write (0xFF) → overflow pulse, count stays 8. Read 8 → 0x01..0x08 in order, each one cycle after rd_en, then empty=1.
- Underflow: rd_en on an empty FIFO → underflow pulse one cycle, rd_data unchanged, count=0.
- Wrap-around: 5 writes, 5 reads, then 8 writes (0x10..0x17) → full=1; the reads return 0x10..0x17.
- Simultaneous: at full, wr_en=rd_en=1 with 0xAA → both accepted, count stays 8, 0xAA emerges last. At empty, both high → count=1, underflow pulse.
- FWFT=1: write 0x5A at edge N → after N+1, empty=0 and rd_data=0x5A before any rd_en. rd_en → empty=1 after the next edge.
